mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle control FSM for the 16-bit TSC CPU; sits directly upstream of the ALU.
- Decodes the latched instruction register and sequences IF/ID/EX/MEM/WB.
- Drives the ALU OP code (FUNC_* from opcodes.v), datapath mux selects, register/PC/IR write enables and the memory request handshake.

Parameters:
- WORD_W, 16, instruction/data word width.
- FUNC_W, 6, ALU OP width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  16  instruction register contents (opcode [15:12], func [5:0]).
- mem_ready  in  1  memory completes current read/write this cycle.
- bcond  in  1  branch condition from datapath comparator, valid in EX.
- alu_op  out  6  ALU OP code.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  0=rt, 1=imm8, 2=const 1.
- pc_src  out  2  0=ALU result, 1=branch target (ALU), 2=jump target {PC[15:12],instr[11:0]}, 3=rs.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  memory address: 0=PC, 1=ALU out.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  0=rt, 1=rd, 2=r2 (link).
- wb_src  out  2  0=ALU out, 1=MDR, 2=PC (link).
- wwd_valid  out  1  one-cycle pulse on WWD.
- is_halted  out  1  high once HLT executes.
- num_inst  out  16  retired-instruction count.

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT. Reset (async, reset_n=0) → IF; all outputs 0; num_inst=0; is_halted=0.
- IF: mem_read=1, i_or_d=0. Hold IF while mem_ready=0. On mem_ready: ir_write=1; PC←PC+1 (alu_src_a=0, alu_src_b=2, alu_op=FUNC_ADD, pc_src=0, pc_write=1); go to ID.
- ID, by opcode:
  - JMP: pc_src=2, pc_write=1, retire, → IF.
  - JAL: additionally reg_write=1, reg_dst=2, wb_src=2 using PC+1.
  - JPR/JRL: pc_src=3, same link rule for JRL.
  - WWD: wwd_valid=1, retire, → IF.
  - HLT: retire, → HALT.
  - All others → EX.
- EX, alu_op per instruction:
  - R-type arithmetic: FUNC_ADD..FUNC_SHR, alu_src_a=1, alu_src_b=0.
  - I-type: FUNC_ADI/ORI/LHI, alu_src_b=1.
  - LWD/SWD: FUNC_LWD/SWD, alu_src_b=1.
  - Branch: alu_src_a=0, alu_src_b=1, alu_op=FUNC_BPC; pc_src=1, pc_write=bcond; retire, → IF.
  - LWD/SWD → MEM; others → WB.
- MEM: i_or_d=1; mem_read (LWD) or mem_write (SWD) held until mem_ready. On ready: SWD retires → IF; LWD → WB.
- WB: reg_write=1, one cycle. reg_dst=1 for R-type, 0 otherwise. wb_src=1 for LWD, 0 otherwise. Retire, → IF.
- Latency, cycles with zero memory wait: R/I-type 4, LWD 5, SWD 4, branch 3, jumps/WWD/HLT 2. Each mem_ready=0 cycle adds one.
- Control outputs are combinational from state+instr (Moore/Mealy mix); only state, num_inst, is_halted are registered.
- HALT is terminal. All enables 0, is_halted=1, exit only by reset.
- Reset mid-MEM: request drops immediately, no write completes from the FSM's side.
- Unknown opcode/func: treated as NOP, retire in ID.
- Retire means num_inst increments by 1, wrapping 0xFFFF→0.

Optional Feature:
- Macro INST_COUNT_EN.
- Defined: num_inst counts as above.
- Undefined: counter logic omitted, num_inst tied to 16'h0000.

Decomposition:
- Shared package/header (opcodes.v): opcode constants, FUNC_* ALU codes, state encodings, mux select encodings.
- Sub-module mc_decode: combinational instr → instruction class + ALU op.
- FSM remains in mc_control_unit.

Test Plan:
- ADD r1,r2→r3 (instr 16'hF6C0), mem_ready=1 → IF,ID,EX(alu_op=FUNC_ADD),WB(reg_write=1, reg_dst=1); num_inst 0→1 after 4 cycles.
- LWD (instr 16'h7405), mem_ready low 2 cycles in MEM → mem_read held, LWD completes in 7 cycles, wb_src=1 in WB.
- BEQ with bcond=1, then bcond=0 → pc_write=1/0 in EX, alu_op=FUNC_BPC, pc_src=1; 3 cycles each.
- JAL (instr 16'hA010) → ID: pc_src=2, pc_write=1, reg_write=1, reg_dst=2, wb_src=2; 2 cycles.
- HLT (instr 16'hF01D) → is_halted=1 next cycle; stays, no pc_write for 10 cycles; reset_n pulse → IF, num_inst=0.
- Assert reset_n=0 mid-MEM of SWD → mem_write drops same cycle (async), state IF after release.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared constants for the TSC multi-cycle control unit:
// opcodes, ALU function codes, FSM states, mux select encodings.
package mc_control_unit_pkg;

  localparam int WORD_W = 16;
  localparam int FUNC_W = 6;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  localparam logic [5:0] FUNC_ADD = 6'd0;
  localparam logic [5:0] FUNC_SUB = 6'd1;
  localparam logic [5:0] FUNC_AND = 6'd2;
  localparam logic [5:0] FUNC_ORR = 6'd3;
  localparam logic [5:0] FUNC_NOT = 6'd4;
  localparam logic [5:0] FUNC_TCP = 6'd5;
  localparam logic [5:0] FUNC_SHL = 6'd6;
  localparam logic [5:0] FUNC_SHR = 6'd7;
  localparam logic [5:0] FUNC_ADI = 6'd8;
  localparam logic [5:0] FUNC_ORI = 6'd9;
  localparam logic [5:0] FUNC_LHI = 6'd10;
  localparam logic [5:0] FUNC_LWD = 6'd11;
  localparam logic [5:0] FUNC_SWD = 6'd12;
  localparam logic [5:0] FUNC_BPC = 6'd13;

  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;
  localparam logic [1:0] SRCB_ONE = 2'd2;

  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_RS  = 2'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_LINK = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_RTYPE, C_ITYPE, C_LWD,
    C_SWD, C_BR, C_JMP, C_JAL,
    C_JPR, C_JRL, C_WWD, C_HLT
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational decode: instr -> instruction class + EX-stage ALU op.
// Ports: instr in; cls, ex_op out.
module mc_decode
  import mc_control_unit_pkg::*;
(
  input  logic [15:0] instr,
  output iclass_t     cls,
  output logic [5:0]  ex_op
);

  logic [3:0] opc;
  logic [5:0] fn;
  logic       unused_bits;

  assign opc         = instr[15:12];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[11:6];

  always_comb begin
    cls   = C_NOP;
    ex_op = FUNC_ADD;
    unique case (1'b1)
      (opc <= OP_BLZ): begin
        cls   = C_BR;
        ex_op = FUNC_BPC;
      end
      (opc == OP_ADI): begin
        cls   = C_ITYPE;
        ex_op = FUNC_ADI;
      end
      (opc == OP_ORI): begin
        cls   = C_ITYPE;
        ex_op = FUNC_ORI;
      end
      (opc == OP_LHI): begin
        cls   = C_ITYPE;
        ex_op = FUNC_LHI;
      end
      (opc == OP_LWD): begin
        cls   = C_LWD;
        ex_op = FUNC_LWD;
      end
      (opc == OP_SWD): begin
        cls   = C_SWD;
        ex_op = FUNC_SWD;
      end
      (opc == OP_JMP): cls = C_JMP;
      (opc == OP_JAL): cls = C_JAL;
      (opc == OP_RTYPE && fn <= FN_SHR): begin
        // R-type func codes line up with FUNC_ADD..FUNC_SHR
        cls   = C_RTYPE;
        ex_op = FUNC_ADD + fn;
      end
      (opc == OP_RTYPE && fn == FN_JPR): cls = C_JPR;
      (opc == OP_RTYPE && fn == FN_JRL): cls = C_JRL;
      (opc == OP_RTYPE && fn == FN_WWD): cls = C_WWD;
      (opc == OP_RTYPE && fn == FN_HLT): cls = C_HLT;
      default: cls = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the 16-bit TSC CPU.
// Ports: clk, reset_n, instr, mem_ready, bcond in; ALU/mux/enable
// controls, wwd_valid, is_halted, num_inst out.
// Macro INST_COUNT_EN enables the retired-instruction counter.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int FUNC_W = 6
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              bcond,
  output logic [FUNC_W-1:0] alu_op,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_src,
  output logic              pc_write,
  output logic              ir_write,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic [1:0]        reg_dst,
  output logic [1:0]        wb_src,
  output logic              wwd_valid,
  output logic              is_halted,
  output logic [WORD_W-1:0] num_inst
);

  state_t     state;
  state_t     nxt;
  iclass_t    cls;
  logic [5:0] ex_op;
  logic       retire;

  mc_decode u_dec (
    .instr (instr[15:0]),
    .cls   (cls),
    .ex_op (ex_op)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IF;
      is_halted <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_ID && cls == C_HLT)
        is_halted <= 1'b1;
    end
  end

  // Outputs are forced low while reset is held so an
  // in-flight memory request drops immediately.
  always_comb begin
    nxt       = state;
    retire    = 1'b0;
    alu_op    = '0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RT;
    pc_src    = PC_ALU;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = DST_RT;
    wb_src    = WB_ALU;
    wwd_valid = 1'b0;
    if (reset_n) begin
      unique case (state)
        S_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            alu_op    = FUNC_ADD;
            alu_src_b = SRCB_ONE;
            pc_write  = 1'b1;
            nxt       = S_ID;
          end
        end
        S_ID: begin
          nxt    = S_IF;
          retire = 1'b1;
          unique case (cls)
            C_JMP: begin
              pc_src   = PC_JMP;
              pc_write = 1'b1;
            end
            C_JAL: begin
              pc_src    = PC_JMP;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              reg_dst   = DST_LINK;
              wb_src    = WB_PC;
            end
            C_JPR: begin
              pc_src   = PC_RS;
              pc_write = 1'b1;
            end
            C_JRL: begin
              pc_src    = PC_RS;
              pc_write  = 1'b1;
              reg_write = 1'b1;
              reg_dst   = DST_LINK;
              wb_src    = WB_PC;
            end
            C_WWD: wwd_valid = 1'b1;
            C_HLT: nxt = S_HALT;
            C_NOP: ;
            default: begin
              retire = 1'b0;
              nxt    = S_EX;
            end
          endcase
        end
        S_EX: begin
          alu_op    = ex_op;
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          nxt       = S_WB;
          unique case (cls)
            C_BR: begin
              alu_src_a = 1'b0;
              pc_src    = PC_BR;
              pc_write  = bcond;
              retire    = 1'b1;
              nxt       = S_IF;
            end
            C_LWD, C_SWD: nxt = S_MEM;
            C_ITYPE: ;
            default: alu_src_b = SRCB_RT;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (cls == C_LWD);
          mem_write = (cls == C_SWD);
          if (mem_ready) begin
            if (cls == C_SWD) begin
              retire = 1'b1;
              nxt    = S_IF;
            end else begin
              nxt = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = (cls == C_RTYPE) ? DST_RD : DST_RT;
          wb_src    = (cls == C_LWD) ? WB_MDR : WB_ALU;
          retire    = 1'b1;
          nxt       = S_IF;
        end
        S_HALT: ;
        default: nxt = S_IF;
      endcase
    end
  end

`ifdef INST_COUNT_EN
  logic [WORD_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (retire)
      cnt <= cnt + 1'b1;
  end

  assign num_inst = cnt;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign num_inst      = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: per-instruction
// cycle plans from the ISA rules, compared every cycle.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        mem_ready = 1'b0;
  logic        bcond = 1'b0;
  logic [5:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic        pc_write;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_src;
  logic        wwd_valid;
  logic        is_halted;
  logic [15:0] num_inst;

  always #5 clk = ~clk;

  mc_control_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .mem_ready (mem_ready),
    .bcond     (bcond),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .pc_src    (pc_src),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wb_src    (wb_src),
    .wwd_valid (wwd_valid),
    .is_halted (is_halted),
    .num_inst  (num_inst)
  );

`ifdef INST_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] op;
    logic       sa;
    logic [1:0] sb;
    logic [1:0] ps;
    logic       pw, irw, iod, mr, mw, rw;
    logic [1:0] rd, wb;
    logic       wv;
  } ov_t;

  typedef struct packed {
    ov_t  o;
    logic rdy, bc, ret, hlt;
  } step_t;

  localparam int K_NOP = 0, K_R = 1, K_I = 2, K_LWD = 3;
  localparam int K_SWD = 4, K_BR = 5, K_JMP = 6, K_JAL = 7;
  localparam int K_JPR = 8, K_JRL = 9, K_WWD = 10, K_HLT = 11;

  ov_t dut_o;
  assign dut_o = {alu_op, alu_src_a, alu_src_b, pc_src,
                  pc_write, ir_write, i_or_d, mem_read,
                  mem_write, reg_write, reg_dst, wb_src,
                  wwd_valid};

  step_t       q[$];
  step_t       cur;
  bit          cur_valid = 1'b0;
  logic [15:0] exp_cnt = 16'h0;
  bit          exp_halt = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [5:0]  rtab [8] = '{FUNC_ADD, FUNC_SUB, FUNC_AND,
                            FUNC_ORR, FUNC_NOT, FUNC_TCP,
                            FUNC_SHL, FUNC_SHR};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  function automatic int kind(input logic [15:0] in);
    int op = int'(in[15:12]);
    int fn = int'(in[5:0]);
    if (op < 4) return K_BR;
    if (op >= 4 && op <= 6) return K_I;
    if (op == 7) return K_LWD;
    if (op == 8) return K_SWD;
    if (op == 9) return K_JMP;
    if (op == 10) return K_JAL;
    if (op == 15) begin
      if (fn < 8) return K_R;
      if (fn == 25) return K_JPR;
      if (fn == 26) return K_JRL;
      if (fn == 28) return K_WWD;
      if (fn == 29) return K_HLT;
    end
    return K_NOP;
  endfunction

  task automatic push(input ov_t o, input bit rdy, input bit bc,
                      input bit ret, input bit hlt);
    step_t s;
    s.o = o; s.rdy = rdy; s.bc = bc; s.ret = ret; s.hlt = hlt;
    q.push_back(s);
  endtask

  task automatic plan(input logic [15:0] in, input bit bc,
                      input int wif, input int wmem);
    ov_t o;
    int  k = kind(in);
    for (int i = 0; i < wif; i++) begin
      o = '0; o.mr = 1'b1;
      push(o, 1'b0, ~bc, 1'b0, 1'b0);
    end
    o = '0; o.mr = 1'b1; o.irw = 1'b1; o.pw = 1'b1;
    o.sb = 2'd2; o.op = FUNC_ADD;
    push(o, 1'b1, ~bc, 1'b0, 1'b0);
    o = '0;
    if (k == K_JMP || k == K_JAL) begin
      o.ps = 2'd2; o.pw = 1'b1;
    end
    if (k == K_JPR || k == K_JRL) begin
      o.ps = 2'd3; o.pw = 1'b1;
    end
    if (k == K_JAL || k == K_JRL) begin
      o.rw = 1'b1; o.rd = 2'd2; o.wb = 2'd2;
    end
    if (k == K_WWD) o.wv = 1'b1;
    if (k >= K_JMP || k == K_NOP) begin
      push(o, 1'b1, ~bc, 1'b1, k == K_HLT);
      return;
    end
    push(o, 1'b1, ~bc, 1'b0, 1'b0);
    o = '0;
    if (k == K_BR) begin
      o.op = FUNC_BPC; o.sb = 2'd1; o.ps = 2'd1; o.pw = bc;
      push(o, 1'b1, bc, 1'b1, 1'b0);
      return;
    end
    o.sa = 1'b1;
    if (k == K_R) o.op = rtab[in[2:0]];
    else o.sb = 2'd1;
    if (k == K_I)
      o.op = (in[15:12] == 4'd4) ? FUNC_ADI :
             (in[15:12] == 4'd5) ? FUNC_ORI : FUNC_LHI;
    if (k == K_LWD) o.op = FUNC_LWD;
    if (k == K_SWD) o.op = FUNC_SWD;
    push(o, 1'b1, bc, 1'b0, 1'b0);
    if (k == K_LWD || k == K_SWD) begin
      o = '0; o.iod = 1'b1;
      o.mr = (k == K_LWD); o.mw = (k == K_SWD);
      for (int i = 0; i < wmem; i++)
        push(o, 1'b0, ~bc, 1'b0, 1'b0);
      push(o, 1'b1, ~bc, k == K_SWD, 1'b0);
      if (k == K_SWD) return;
    end
    o = '0; o.rw = 1'b1;
    o.rd = (k == K_R) ? 2'd1 : 2'd0;
    o.wb = (k == K_LWD) ? 2'd1 : 2'd0;
    push(o, 1'b1, ~bc, 1'b1, 1'b0);
  endtask

  task automatic run(input int n);
    step_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      cur = e;
      mem_ready = e.rdy;
      bcond = e.bc;
      cur_valid = 1'b1;
      @(posedge clk); #1;
      if (e.ret) exp_cnt = exp_cnt + 16'd1;
      if (e.hlt) exp_halt = 1'b1;
    end
    cur_valid = 1'b0;
  endtask

  task automatic do_instr(input string nm, input logic [15:0] in,
                          input bit bc, input int wif,
                          input int wmem, input int len);
    q.delete();
    plan(in, bc, wif, wmem);
    chk({nm, "_len"}, q.size(), len);
    instr = in;
    run(q.size());
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      chk("outputs", dut_o, cur.o);
      chk("num_inst", num_inst, CNT_ON ? exp_cnt : 16'h0);
      chk("is_halted", is_halted, exp_halt);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ov_t z;
    z = '0;
    #2;
    chk("reset_outputs", dut_o, z);
    chk("reset_num_inst", num_inst, 16'h0);
    chk("reset_halted", is_halted, 1'b0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    do_instr("add", 16'hF6C0, 1'b0, 0, 0, 4);
    chk("add_count", num_inst, CNT_ON ? 16'd1 : 16'd0);
    do_instr("sub_wait", 16'hF6C1, 1'b0, 1, 0, 5);
    do_instr("shr", 16'hF6C7, 1'b1, 0, 0, 4);
    do_instr("adi", 16'h4105, 1'b0, 0, 0, 4);
    do_instr("ori", 16'h5105, 1'b1, 0, 0, 4);
    do_instr("lhi", 16'h6105, 1'b0, 0, 0, 4);
    do_instr("lwd", 16'h7405, 1'b0, 0, 2, 7);
    do_instr("swd", 16'h8405, 1'b0, 0, 0, 4);
    do_instr("beq_t", 16'h1203, 1'b1, 0, 0, 3);
    do_instr("beq_f", 16'h1203, 1'b0, 0, 0, 3);
    do_instr("jal", 16'hA010, 1'b0, 0, 0, 2);
    do_instr("jmp", 16'h9010, 1'b0, 0, 0, 2);
    do_instr("jpr", 16'hF019, 1'b0, 0, 0, 2);
    do_instr("jrl", 16'hF01A, 1'b0, 0, 0, 2);
    do_instr("wwd", 16'hF01C, 1'b0, 0, 0, 2);
    do_instr("nop_op", 16'hB000, 1'b0, 0, 0, 2);
    do_instr("nop_fn", 16'hF008, 1'b0, 0, 0, 2);
    chk("count_17", num_inst, CNT_ON ? 16'd17 : 16'd0);
    do_instr("hlt", 16'hF01D, 1'b0, 0, 0, 2);

    q.delete();
    for (int i = 0; i < 10; i++)
      push(z, 1'b1, 1'b0, 1'b0, 1'b0);
    run(10);

    mem_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("hlt_rst_halted", is_halted, 1'b0);
    chk("hlt_rst_count", num_inst, 16'h0);
    exp_cnt = 16'h0;
    exp_halt = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_instr("add_after", 16'hF6C0, 1'b0, 0, 0, 4);

    q.delete();
    instr = 16'h8405;
    plan(16'h8405, 1'b0, 0, 3);
    run(4);
    mem_ready = 1'b0;
    #2;
    chk("mid_mem_write", mem_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_outputs", dut_o, z);
    q.delete();
    exp_cnt = 16'h0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_instr("add_rst", 16'hF6C0, 1'b0, 1, 0, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
